// File: rtl/lc3_rf_pkg.sv
// Shared constants and helpers for the LC3 register file / scoreboard slice.
package lc3_rf_pkg;

   // Condition-code encodings, {N,Z,P}; exactly one bit is ever set.
   localparam logic [2:0] NZP_N     = 3'b100;
   localparam logic [2:0] NZP_Z     = 3'b010;
   localparam logic [2:0] NZP_P     = 3'b001;
   localparam logic [2:0] NZP_RESET = NZP_Z;

   // Widest data word nzp_of() accepts; callers zero-extend into it.
   localparam int NZP_MAX_W = 64;

   // Classify a w-bit value (zero-extended into data) as negative/zero/positive.
   function automatic logic [2:0] nzp_of(input logic [NZP_MAX_W-1:0] data,
                                         input int unsigned          w);
      logic [NZP_MAX_W-1:0] sh;
      sh = data >> (w - 1);
      if (sh[0])           return NZP_N;
      else if (data == '0) return NZP_Z;
      else                 return NZP_P;
   endfunction

endpackage

// File: rtl/lc3_scoreboard.sv
// Per-register busy bits: Decode claims destinations, Writeback releases them.
// Writeback in the same cycle is forwarded so a register being written now
// already counts as free for both issue and read-side hazard checks.
module lc3_scoreboard
   import lc3_rf_pkg::*;
#(
   parameter  int NUM_REG = 8,
   parameter  int NUM_RD  = 2,
   localparam int AW      = $clog2(NUM_REG)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_RD*AW-1:0] i_rd_addr,
   input  logic                 i_wr_en,
   input  logic [AW-1:0]        i_wr_addr,
   input  logic                 i_issue_en,
   input  logic [AW-1:0]        i_issue_addr,
   output logic [NUM_RD-1:0]    o_rd_busy,
   output logic                 o_issue_ok
);

   logic [NUM_REG-1:0] r_busy;
   logic [NUM_REG-1:0] w_busy_nxt;

   assign o_issue_ok = !r_busy[i_issue_addr] || (i_wr_en && (i_wr_addr == i_issue_addr));

   // Next busy vector: clear on writeback, then set on accepted claim so a
   // back-to-back producer to the same register keeps it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_wr_en)
         w_busy_nxt[i_wr_addr] = 1'b0;
      if (i_issue_en && o_issue_ok)
         w_busy_nxt[i_issue_addr] = 1'b1;
   end

   // Busy register; reset discards every outstanding claim.
   always_ff @(posedge clock) begin
      if (reset) r_busy <= '0;
      else       r_busy <= w_busy_nxt;
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra         = i_rd_addr[g*AW +: AW];
      assign o_rd_busy[g] = r_busy[w_ra] && !(i_wr_en && (i_wr_addr == w_ra));
   end

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC3 register file: storage, write-first read bypass, NZP flags, and the
// destination scoreboard Decode uses to stall on RAW hazards.
module lc3_regfile_sb
   import lc3_rf_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int NUM_REG = 8,
   parameter  int NUM_RD  = 2,
   localparam int AW      = $clog2(NUM_REG)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] o_rd_data,
   output logic [NUM_RD-1:0]        o_rd_busy,
   input  logic                     i_wr_en,
   input  logic [AW-1:0]            i_wr_addr,
   input  logic [DATA_W-1:0]        i_wr_data,
   input  logic                     i_wr_setcc,
   input  logic                     i_issue_en,
   input  logic [AW-1:0]            i_issue_addr,
   output logic                     o_issue_ok,
   output logic [2:0]               o_nzp
);

   logic [NUM_REG-1:0][DATA_W-1:0] r_regs;
   logic [2:0]                     r_nzp;

   // Register storage: single write port, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset)        r_regs            <= '0;
      else if (i_wr_en) r_regs[i_wr_addr] <= i_wr_data;
   end

   // Condition codes follow the written value only when the instruction sets them.
   always_ff @(posedge clock) begin
      if (reset)                        r_nzp <= NZP_RESET;
      else if (i_wr_en && i_wr_setcc)   r_nzp <= nzp_of(NZP_MAX_W'(i_wr_data), DATA_W);
   end

   assign o_nzp = r_nzp;

   // Read ports: a same-cycle writeback wins over stored contents.
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra = i_rd_addr[g*AW +: AW];
      assign o_rd_data[g*DATA_W +: DATA_W] =
         (i_wr_en && (i_wr_addr == w_ra)) ? i_wr_data : r_regs[w_ra];
   end

   lc3_scoreboard #(
      .NUM_REG (NUM_REG),
      .NUM_RD  (NUM_RD)
   ) u_sb (
      .clock        (clock),
      .reset        (reset),
      .i_rd_addr    (i_rd_addr),
      .i_wr_en      (i_wr_en),
      .i_wr_addr    (i_wr_addr),
      .i_issue_en   (i_issue_en),
      .i_issue_addr (i_issue_addr),
      .o_rd_busy    (o_rd_busy),
      .o_issue_ok   (o_issue_ok)
   );

endmodule
